// File: rtl/instr_enc.sv
// instr_enc: packs RV32I fields and an immediate into an instruction word, flags out-of-range immediates, buffers results in a 2-entry FIFO
module instr_enc #(
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [2:0]       EXTOP,
  input  logic [6:0]       OPCODE,
  input  logic [4:0]       RD,
  input  logic [4:0]       RS1,
  input  logic [4:0]       RS2,
  input  logic [2:0]       FUNCT3,
  input  logic [6:0]       FUNCT7,
  input  logic [31:0]      IMM,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [31:0]      OUT_INSTR,
  output logic             OUT_ERR,
  output logic [CNT_W-1:0] ERR_CNT
);
  logic [31:0] enc;
  logic        err;
  logic [32:0] mem [2];
  logic [32:0] last;
  logic        wr_ptr, rd_ptr;
  logic [1:0]  count;
  logic        push, pop;
  always_comb begin
    enc = '0;
    err = 1'b0;
    case (EXTOP)
      3'b000: begin
        enc = {IMM[11:0], RS1, FUNCT3, RD, OPCODE};
        err = ~(&IMM[31:11] | ~|IMM[31:11]);
      end
      3'b001: begin
        enc = {IMM[31:12], RD, OPCODE};
        err = |IMM[11:0];
      end
      3'b010: begin
        enc = {IMM[11:5], RS2, RS1, FUNCT3, IMM[4:0], OPCODE};
        err = ~(&IMM[31:11] | ~|IMM[31:11]);
      end
      3'b011: begin
        enc = {IMM[12], IMM[10:5], RS2, RS1, FUNCT3, IMM[4:1], IMM[11], OPCODE};
        err = ~(&IMM[31:12] | ~|IMM[31:12]) | IMM[0];
      end
      3'b100: begin
        enc = {IMM[20], IMM[10:1], IMM[11], IMM[19:12], RD, OPCODE};
        err = ~(&IMM[31:20] | ~|IMM[31:20]) | IMM[0];
      end
      3'b101: enc = {FUNCT7, RS2, RS1, FUNCT3, RD, OPCODE};
      default: err = 1'b1;
    endcase
  end
  assign IN_READY  = (count != 2'd2) & ~RST;
  assign OUT_VALID = count != 2'd0;
  assign push      = IN_VALID & IN_READY;
  assign pop       = OUT_VALID & OUT_READY;
  // when empty the outputs keep showing the most recently popped entry
  assign {OUT_INSTR, OUT_ERR} = OUT_VALID ? mem[rd_ptr] : last;
  always_ff @(posedge CLK) begin
    if (RST) begin
      mem[0]  <= '0;
      mem[1]  <= '0;
      last    <= '0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      count   <= 2'd0;
      ERR_CNT <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {enc, err};
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
        last   <= mem[rd_ptr];
      end
      count <= count + {1'b0, push} - {1'b0, pop};
      if (push & err & ~&ERR_CNT) ERR_CNT <= ERR_CNT + 1'b1;
    end
  end
endmodule

// File: doc/instr_enc.md
# instr_enc

- Instruction encoder for the RISC-V datapath. It performs the inverse of the immediate extractor: it takes decoded fields plus a 32-bit immediate and packs them into a 32-bit instruction word.
- It also checks that the immediate fits the selected format and flags any that does not.
- It sits between the test/boot-ROM generator and instruction memory. It uses a valid/ready handshake on both sides and holds results in a 2-entry output FIFO.

## Interface
Parameters:
- CNT_W, 8, width of the saturating error counter ERR_CNT

Ports:
- CLK  input  1  clock; all state updates on rising edge
- RST  input  1  synchronous reset, active-high
- IN_VALID  input  1  fields on the inputs below are valid
- IN_READY  output  1  encoder can accept an input this cycle
- EXTOP  input  3  format select: 000 I, 001 U, 010 S, 011 B, 100 J, 101 R, 110/111 illegal
- OPCODE  input  7  placed at [6:0]
- RD  input  5  placed at [11:7] for I/U/J/R formats
- RS1  input  5  placed at [19:15] for I/S/B/R formats
- RS2  input  5  placed at [24:20] for S/B/R formats
- FUNCT3  input  3  placed at [14:12] for I/S/B/R formats
- FUNCT7  input  7  placed at [31:25] for R format only
- IMM  input  32  full signed immediate; ignored for R format
- OUT_VALID  output  1  head FIFO entry is valid
- OUT_READY  input  1  consumer takes the head entry
- OUT_INSTR  output  32  encoded instruction at FIFO head
- OUT_ERR  output  1  range/format error for the head entry
- ERR_CNT  output  CNT_W  count of accepted inputs that had an error, saturating

## Operation
- Encoding is standard RV32I. Fields a format does not use are forced to 0.
- I format: [31:20]=IMM[11:0].
- U format: [31:12]=IMM[31:12].
- S format: [31:25]=IMM[11:5], [11:7]=IMM[4:0].
- B format: [31]=IMM[12], [30:25]=IMM[10:5], [11:8]=IMM[4:1], [7]=IMM[11].
- J format: [31]=IMM[20], [30:21]=IMM[10:1], [20]=IMM[11], [19:12]=IMM[19:12].
- R format: [31:25]=FUNCT7.
- Error rules; the word is always still encoded from the low bits:
  - I, S: ERR if IMM[31:11] is not all-equal.
  - B: ERR if IMM[31:12] is not all-equal, or IMM[0]=1.
  - J: ERR if IMM[31:20] is not all-equal, or IMM[0]=1.
  - U: ERR if IMM[11:0]≠0.
  - R: never ERR.
  - EXTOP 110/111: OUT_INSTR=0, ERR=1.
- Encoding and the error check are combinational from the inputs. On an accepted input, the {instr, err} pair is written into the FIFO.
- FIFO:
  - Depth 2, occupancy count 0..2.
  - Push = IN_VALID & IN_READY.
  - Pop = OUT_VALID & OUT_READY.
  - Both in the same cycle: count unchanged, ordering preserved.
- IN_READY = (count≠2) & ~RST. It does not depend on OUT_READY.
- OUT_VALID = (count≠0). OUT_INSTR and OUT_ERR show the head entry and are held stable while OUT_VALID & ~OUT_READY.
- ERR_CNT:
  - Increments on every push whose err=1.
  - Saturates at 2^CNT_W−1.
  - Is not decremented by pops.

## Timing
- Reset, while RST is high at an edge:
  - count=0, FIFO pointers=0, ERR_CNT=0.
  - OUT_VALID=0, OUT_INSTR=0, OUT_ERR=0.
  - IN_READY=0 during RST and 1 in the first cycle after.
- Reset mid-operation flushes all entries; pending outputs are lost.
- Latency: an input accepted at edge N is visible on the outputs with OUT_VALID=1 after edge N (1 cycle), provided the FIFO was empty.
- Throughput: 1 word per cycle when OUT_READY is held high (count steady at 1).
- Full: with count=2, IN_READY=0. A pop at count=2 makes IN_READY=1 in the next cycle, not the same cycle.
- Empty: OUT_READY with count=0 has no effect. OUT_INSTR holds its last value, or 0 after reset.
- Push of an error entry while ERR_CNT is saturated: ERR_CNT holds, OUT_ERR is still 1 for that entry.

## Test plan
- Basic encodes, one per cycle, OUT_READY=1; each OUT_INSTR one cycle after acceptance, OUT_ERR=0:
  - I, OPCODE=0010011, RD=1, RS1=0, FUNCT3=0, IMM=5 -> 0x00500093.
  - U, OPCODE=0110111, RD=2, IMM=0x12345000 -> 0x12345137.
  - S, OPCODE=0100011, FUNCT3=010, RS1=2, RS2=5, IMM=8 -> 0x00512423.
- Branch/jump encodes:
  - B, OPCODE=1100011, RS1=RS2=0, FUNCT3=0, IMM=0xFFFFFFFC -> 0xFE000EE3, ERR=0.
  - J, OPCODE=1101111, RD=1, IMM=0x800 -> 0x001000EF, ERR=0.
- Range errors:
  - I addi with IMM=0x800 -> 0x80000093, OUT_ERR=1, ERR_CNT 0->1.
  - B with IMM=6 (bit0=0) -> ERR=0.
  - J with IMM=3 -> ERR=1.
  - EXTOP=111 -> OUT_INSTR=0, ERR=1.
- Backpressure:
  - OUT_READY=0, push 3 back-to-back -> first two accepted, IN_READY=0 from the cycle after the 2nd push.
  - Raise OUT_READY -> words exit in order; the 3rd is accepted the cycle after the first pop.
- Saturation: CNT_W=2, push 5 error inputs -> ERR_CNT goes 1, 2, 3, 3, 3.
- Reset mid-stream: count=2, assert RST for 1 cycle -> OUT_VALID=0, OUT_INSTR=0, ERR_CNT=0, IN_READY=0 during RST then 1.
